serial_subtractor: RTL and testbench



---
 rtl/sub_pkg.sv | 17 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 109 ++++++++++
 tb/tb_serial_subtractor.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 8;

  // Bit counter width: one spare bit so the count never wraps mid-operation.
  function automatic int unsigned cnt_width(input int unsigned w);
    return 32'($clog2(w)) + 32'd1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b over WIDTH cycles, LSB first.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             diff_bit,
  output logic             diff_valid,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_d;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] diff_sh;
  logic [WIDTH-1:0] diff_next;
  logic [CW-1:0]    cnt;
  logic             bin;
  logic             cell_d;
  logic             cell_bout;
  logic             last_bit;

  full_subtractor u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (bin),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Lower WIDTH-1 result bits live in diff_sh; the current cell bit completes the word.
  assign diff_next = {cell_d, diff_sh};
  assign last_bit  = (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state decode and the combinational serial output
  always_comb begin
    state_d    = state;
    diff_valid = 1'b0;
    diff_bit   = 1'b0;
    case (state)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        diff_valid = 1'b1;
        diff_bit   = cell_d;
        if (last_bit) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand shifters, borrow chain, counter and registered results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      diff_sh <= '0;
      cnt     <= '0;
      bin     <= 1'b0;
      diff    <= '0;
      borrow  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      busy <= (state_d != IDLE);
      done <= (state_d == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            bin  <= 1'b0;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          diff_sh <= diff_next[WIDTH-1:1];
          bin     <= cell_bout;
          cnt     <= cnt + CW'(1);
          if (last_bit) begin
            diff   <= diff_next;
            borrow <= cell_bout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: driver pushes expected results, monitor checks.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         borrow;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         diff_bit;
  logic         diff_valid;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   cont_mode = 1'b0;
  bit   stim_done = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .diff_bit   (diff_bit),
    .diff_valid (diff_valid),
    .done       (done),
    .diff       (diff),
    .borrow     (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer subtraction, wrapped to W bits; borrow when negative.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int   r;
    r        = int'(x) - int'(y);
    e.diff   = W'(r);
    e.borrow = (r < 0);
    return e;
  endfunction

  function automatic void chk(input bit ok, input string name,
                              input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
  endfunction

  // Single start pulse; returns once the design is back in IDLE.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y);
    a = x; b = y; start = 1'b1;
    q.push_back(model(x, y));
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    repeat (W + 1) @(posedge clk);
    #1;
  endtask

  // Stimulus
  initial begin
    start = 1'b0; a = '0; b = '0; rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    do_op(8'd100, 8'd37);
    do_op(8'd5,   8'd9);
    do_op(8'h55,  8'h55);
    do_op(8'd0,   8'd255);

    // start re-asserted mid-RUN must be ignored
    a = 8'd250; b = 8'd3; start = 1'b1;
    q.push_back(model(8'd250, 8'd3));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk); #1;
    a = 8'd1; b = 8'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (W - 2) @(posedge clk); #1;

    // reset after three RUN cycles discards the operation
    a = 8'd150; b = 8'd20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;

    do_op(8'd200, 8'd100);
    repeat (20) do_op(W'($urandom), W'($urandom));

    // start held high: back-to-back operations
    cont_mode = 1'b1;
    start     = 1'b1;
    for (int i = 0; i < 500; i++) begin
      a = W'($urandom); b = W'($urandom);
      q.push_back(model(a, b));
      @(posedge clk); #1;
      a = W'($urandom); b = W'($urandom);
      repeat (W + 1) @(posedge clk);
      #1;
    end
    start = 1'b0;

    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    cont_mode = 1'b0;
    stim_done = 1'b1;
  end

  // Monitor: samples on the falling edge, owns all comparisons
  logic [W-1:0] ser;
  int           sidx      = 0;
  int           brun      = 0;
  int           cyc       = 0;
  int           prev_done = 0;
  bit           prev_ok   = 1'b0;
  exp_t         e;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk({busy, diff_bit, diff_valid, done, borrow, diff} == '0, "reset_outputs",
          64'({busy, diff_bit, diff_valid, done, borrow, diff}), 64'd0);
      q.delete();
      sidx    = 0;
      brun    = 0;
      prev_ok = 1'b0;
    end else begin
      if (!diff_valid) begin
        if (diff_bit !== 1'b0) chk(1'b0, "diff_bit_when_invalid", 64'(diff_bit), 64'd0);
      end else begin
        if (sidx < int'(W)) ser[sidx] = diff_bit;
        sidx++;
      end

      if (busy) brun++;
      else if (brun != 0) begin
        chk(brun == int'(W) + 1, "busy_length", 64'(brun), 64'(W + 1));
        brun = 0;
      end

      if (done) begin
        if (q.size() == 0) begin
          chk(1'b0, "unexpected_done", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk(diff == e.diff, "diff", 64'(diff), 64'(e.diff));
          chk(borrow == e.borrow, "borrow", 64'(borrow), 64'(e.borrow));
          chk(ser == e.diff, "serial_bits", 64'(ser), 64'(e.diff));
          chk(sidx == int'(W), "serial_count", 64'(sidx), 64'(W));
        end
        sidx = 0;
        if (cont_mode) begin
          if (prev_ok) chk(cyc - prev_done == int'(W) + 2, "done_period",
                           64'(cyc - prev_done), 64'(W + 2));
          prev_done = cyc;
          prev_ok   = 1'b1;
        end else begin
          prev_ok = 1'b0;
        end
      end
    end

    if (stim_done || cyc > 60000) begin
      chk(q.size() == 0 && cyc <= 60000, "drain", 64'(q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
    end
  end

endmodule
